// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// The fetch port is owner 0 and the data port is owner 1 throughout the design.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_CYCLES = 2;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_IF) ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker: a lone requester wins outright, and a
// tie goes to whichever port did not own the previous access.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic [1:0] gnt,
  output owner_e     winner
);

  // Pick the winner and produce its one-hot grant.
  always_comb begin
    gnt    = 2'b00;
    winner = OWN_IF;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        winner = OWN_IF;
      end
      2'b10: begin
        gnt    = 2'b10;
        winner = OWN_D;
      end
      2'b11: begin
        winner = other_owner(last_owner);
        gnt    = (other_owner(last_owner) == OWN_D) ? 2'b10 : 2'b01;
      end
      default: begin
        gnt    = 2'b00;
        winner = OWN_IF;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between the fetch port and the data port,
// sequencing each access through WAIT_CYCLES memory cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                WCNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_ZERO = WCNT_W'(0);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
    $error("mem_port_arbiter: WAIT_CYCLES must be at least 1");
  end

  state_e            state_r, state_s;
  logic [WCNT_W-1:0] wcnt_r, wcnt_s;
  owner_e            last_owner_r, owner_r, winner_s, resp_owner_s;
  logic [1:0]        req_s, pick_s;
  logic [ADDR_W-1:0] addr_r, win_addr_s;
  logic [DATA_W-1:0] wdata_r, win_wdata_s, resp_rdata_s;
  logic              we_r, win_we_s;
  logic              grant_s, in_range_s;
  logic              resp_load_s, resp_err_s;
  logic              mem_en_s, mem_we_s;
  logic              if_rvalid_r, if_err_r, d_rvalid_r, d_err_r;
  logic [DATA_W-1:0] if_rdata_r, d_rdata_r;

  assign req_s = {d_req, if_req};

  arb_rr2 u_arb (
    .req        (req_s),
    .last_owner (last_owner_r),
    .gnt        (pick_s),
    .winner     (winner_s)
  );

  // Route the winning port's request fields toward the latch stage.
  always_comb begin
    win_addr_s  = if_addr;
    win_we_s    = 1'b0;
    win_wdata_s = DATA_ZERO;
    if (winner_s == OWN_D) begin
      win_addr_s  = d_addr;
      win_we_s    = d_we;
      win_wdata_s = d_wdata;
    end else begin
      win_addr_s  = if_addr;
      win_we_s    = 1'b0;
      win_wdata_s = DATA_ZERO;
    end
  end

  // Extended by one bit so a DEPTH of 2**ADDR_W still compares correctly.
  assign in_range_s = ({1'b0, win_addr_s} < DEPTH_LIM);
  // rst_n gates the grant so that no output is high while reset is held.
  assign grant_s    = (state_r == IDLE) && (req_s != 2'b00) && rst_n;

  // Next-state, memory strobes and response staging.
  always_comb begin
    state_s      = state_r;
    wcnt_s       = wcnt_r;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    resp_load_s  = 1'b0;
    resp_owner_s = owner_r;
    resp_rdata_s = DATA_ZERO;
    resp_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_s && in_range_s) begin
          state_s = WAIT;
          wcnt_s  = WCNT_INIT;
        end else if (grant_s) begin
          state_s      = RESP;
          resp_load_s  = 1'b1;
          resp_owner_s = winner_s;
          resp_err_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        mem_en_s = 1'b1;
        if (wcnt_r == WCNT_ZERO) begin
          mem_we_s     = we_r;
          state_s      = RESP;
          resp_load_s  = 1'b1;
          resp_rdata_s = we_r ? DATA_ZERO : mem_rdata;
        end else begin
          wcnt_s = wcnt_r - WCNT_ONE;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      wcnt_r  <= WCNT_ZERO;
    end else begin
      state_r <= state_s;
      wcnt_r  <= wcnt_s;
    end
  end

  // Latch the granted request and remember who owned it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= ADDR_ZERO;
      wdata_r      <= DATA_ZERO;
      we_r         <= 1'b0;
      owner_r      <= OWN_IF;
      last_owner_r <= OWN_D;
    end else if (grant_s) begin
      addr_r       <= win_addr_s;
      wdata_r      <= win_wdata_s;
      we_r         <= win_we_s;
      owner_r      <= winner_s;
      last_owner_r <= winner_s;
    end
  end

  // Per-port response registers; rdata/err hold until that port's next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= DATA_ZERO;
      if_err_r    <= 1'b0;
      d_rvalid_r  <= 1'b0;
      d_rdata_r   <= DATA_ZERO;
      d_err_r     <= 1'b0;
    end else begin
      if_rvalid_r <= resp_load_s && (resp_owner_s == OWN_IF);
      d_rvalid_r  <= resp_load_s && (resp_owner_s == OWN_D);
      if (resp_load_s && (resp_owner_s == OWN_IF)) begin
        if_rdata_r <= resp_rdata_s;
        if_err_r   <= resp_err_s;
      end
      if (resp_load_s && (resp_owner_s == OWN_D)) begin
        d_rdata_r <= resp_rdata_s;
        d_err_r   <= resp_err_s;
      end
    end
  end

  assign if_gnt    = grant_s & pick_s[0];
  assign d_gnt     = grant_s & pick_s[1];
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign if_err    = if_err_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;
  assign d_err     = d_err_r;
  assign mem_en    = mem_en_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_en_s ? addr_r : ADDR_ZERO;
  assign mem_wdata = mem_en_s ? wdata_r : DATA_ZERO;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural memory and a
// reference model of expected responses, latencies and memory contents.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int WAITC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] tb_mem  [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic          pre_we;
  logic [5:0]    pre_idx;
  logic [DW-1:0] pre_val;

  int nvec = 0;
  int nerr = 0;

  // Observations gathered by run_single
  int            o_gnt, o_rv, stray;
  logic [DW-1:0] o_rdata;
  logic          o_err;
  logic [19:0]   en_mask, we_mask;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd64) ? tb_mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_idx] <= pre_val;
    else if (mem_en && mem_we && (mem_addr < 32'd64)) tb_mem[mem_addr[5:0]] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Reference model: expected outcome of a lone access, updating ref_mem for writes.
  task automatic model_access(input bit pd, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd,
                              output logic err, output int en_n, output logic [19:0] wmask);
    err   = (addr >= 64);
    lat   = err ? 1 : WAITC + 1;
    rd    = (err || (pd && we)) ? 32'h0 : ref_mem[addr[5:0]];
    en_n  = err ? 0 : WAITC;
    wmask = (pd && we && !err) ? (20'd1 << WAITC) : 20'd0;
    if (pd && we && !err) ref_mem[addr[5:0]] = wd;
  endtask

  // Drive one request on one port and record what the DUT does, cycle by cycle.
  task automatic run_single(input bit pd, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
    o_gnt = -1; o_rv = -1; stray = 0; o_rdata = 32'h0; o_err = 1'b0;
    en_mask = 20'd0; we_mask = 20'd0;
    if (pd) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((pd ? d_gnt : if_gnt) && (o_gnt < 0)) o_gnt = k;
      if (pd ? if_gnt : d_gnt) stray++;
      if (pd ? if_rvalid : d_rvalid) stray++;
      if (mem_en) en_mask[k] = 1'b1;
      if (mem_we) we_mask[k] = 1'b1;
      if (pd ? d_rvalid : if_rvalid) begin
        o_rv    = k;
        o_rdata = pd ? d_rdata : if_rdata;
        o_err   = pd ? d_err : if_err;
      end
      @(posedge clk); #1;
      if (o_gnt == k) begin if_req = 1'b0; d_req = 1'b0; end
      if (o_rv >= 0) break;
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; if_addr = 32'd1; d_addr = 32'd2; d_wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #2;
    nvec++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_en, mem_we} !== 8'h00) begin
      nerr++;
      $display("FAIL reset_flags: got %b required 00000000",
               {if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_en, mem_we});
    end
    nvec++;
    if (if_rdata !== 32'h0) begin nerr++; $display("FAIL reset_if_rdata: got %h required 0", if_rdata); end
    nvec++;
    if (d_rdata !== 32'h0) begin nerr++; $display("FAIL reset_d_rdata: got %h required 0", d_rdata); end
    nvec++;
    if (mem_addr !== 32'h0) begin nerr++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    nvec++;
    if (mem_wdata !== 32'h0) begin nerr++; $display("FAIL reset_mem_wdata: got %h required 0", mem_wdata); end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    run_single(1'b0, 1'b0, 32'd5, 32'h0);
    nvec++;
    if (o_gnt !== 0) begin nerr++; $display("FAIL fetch_gnt: got cycle %0d required 0", o_gnt); end
    nvec++;
    if (en_mask !== 20'b110) begin nerr++; $display("FAIL fetch_mem_en: got %b required 110", en_mask); end
    nvec++;
    if (o_rv !== 3) begin nerr++; $display("FAIL fetch_rvalid_cycle: got %0d required 3", o_rv); end
    nvec++;
    if (o_rdata !== 32'h00A0_0005) begin nerr++; $display("FAIL fetch_rdata: got %h required 00a00005", o_rdata); end
    nvec++;
    if ((o_err !== 1'b0) || (stray !== 0)) begin
      nerr++; $display("FAIL fetch_err_stray: got err %b stray %0d required 0 0", o_err, stray);
    end
  endtask

  task automatic test_write_then_fetch();
    run_single(1'b1, 1'b1, 32'd10, 32'hDEAD_BEEF);
    ref_mem[10] = 32'hDEAD_BEEF;
    nvec++;
    if (we_mask !== 20'b100) begin nerr++; $display("FAIL write_mem_we: got %b required 100", we_mask); end
    nvec++;
    if ((o_rv !== 3) || (o_rdata !== 32'h0) || (o_err !== 1'b0)) begin
      nerr++; $display("FAIL write_resp: got cyc %0d rdata %h err %b required 3 0 0", o_rv, o_rdata, o_err);
    end
    run_single(1'b0, 1'b0, 32'd10, 32'h0);
    nvec++;
    if ((o_rv !== 3) || (o_rdata !== 32'hDEAD_BEEF)) begin
      nerr++; $display("FAIL write_readback: got cyc %0d rdata %h required 3 deadbeef", o_rv, o_rdata);
    end
  endtask

  task automatic test_out_of_range();
    run_single(1'b1, 1'b0, 32'd64, 32'h0);
    nvec++;
    if ((o_gnt !== 0) || (o_rv !== 1)) begin
      nerr++; $display("FAIL oor_timing: got gnt %0d rvalid %0d required 0 1", o_gnt, o_rv);
    end
    nvec++;
    if ((o_err !== 1'b1) || (o_rdata !== 32'h0)) begin
      nerr++; $display("FAIL oor_resp: got err %b rdata %h required 1 0", o_err, o_rdata);
    end
    nvec++;
    if (en_mask !== 20'd0) begin nerr++; $display("FAIL oor_mem_en: got %b required 0", en_mask); end
    nvec++;
    if (if_rdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL oor_if_hold: got %h required deadbeef", if_rdata); end
    run_single(1'b1, 1'b0, 32'd63, 32'h0);
    nvec++;
    if ((o_rv !== 3) || (o_err !== 1'b0) || (o_rdata !== ref_mem[63])) begin
      nerr++; $display("FAIL edge_63: got cyc %0d err %b rdata %h required 3 0 %h", o_rv, o_err, o_rdata, ref_mem[63]);
    end
    run_single(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h5555_AAAA);
    nvec++;
    if ((o_rv !== 1) || (o_err !== 1'b1) || (we_mask !== 20'd0) || (en_mask !== 20'd0)) begin
      nerr++; $display("FAIL oor_max_write: got cyc %0d err %b we %b en %b required 1 1 0 0", o_rv, o_err, we_mask, en_mask);
    end
  endtask

  task automatic test_round_robin();
    int g_own [4];
    int g_cyc [4];
    int n, nrv, bad, last, expo;
    test_reset();
    for (int i = 0; i < 4; i++) begin g_own[i] = -1; g_cyc[i] = -100; end
    n = 0; nrv = 0; bad = 0;
    if_req = 1'b1; if_addr = 32'd1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (if_gnt && d_gnt) bad++;
      if (if_gnt && (n < 4)) begin g_own[n] = 0; g_cyc[n] = k; n++; end
      else if (d_gnt && (n < 4)) begin g_own[n] = 1; g_cyc[n] = k; n++; end
      if (if_rvalid) begin nrv++; if (if_rdata !== ref_mem[1]) bad++; end
      if (d_rvalid) begin nrv++; if (d_rdata !== ref_mem[2]) bad++; end
      @(posedge clk); #1;
      if (nrv == 4) break;
    end
    if_req = 1'b0; d_req = 1'b0;
    last = 1;
    for (int i = 0; i < 4; i++) begin
      expo = 1 - last;
      nvec++;
      if (g_own[i] !== expo) begin nerr++; $display("FAIL rr_owner[%0d]: got %0d required %0d", i, g_own[i], expo); end
      last = expo;
      if (i > 0) begin
        nvec++;
        if ((g_cyc[i] - g_cyc[i-1]) !== (WAITC + 2)) begin
          nerr++; $display("FAIL rr_spacing[%0d]: got %0d required %0d", i, g_cyc[i] - g_cyc[i-1], WAITC + 2);
        end
      end
    end
    nvec++;
    if ((bad !== 0) || (g_cyc[0] !== 0)) begin
      nerr++; $display("FAIL rr_data: got bad %0d first %0d required 0 0", bad, g_cyc[0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int sc;
    logic [DW-1:0] newv;
    newv = ~ref_mem[20];
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = newv;
    #1;
    nvec++;
    if (d_gnt !== 1'b1) begin nerr++; $display("FAIL midrst_gnt: got %b required 1", d_gnt); end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata} !== 136'h0) begin
      nerr++; $display("FAIL midrst_outputs: got en %b addr %h wdata %h required all zero", mem_en, mem_addr, mem_wdata);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    sc = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (if_rvalid || d_rvalid || mem_en) sc++;
      @(posedge clk); #1;
    end
    nvec++;
    if (sc !== 0) begin nerr++; $display("FAIL midrst_stale: got %0d stale cycles required 0", sc); end
    nvec++;
    if (tb_mem[20] !== ref_mem[20]) begin nerr++; $display("FAIL midrst_nowrite: got %h required %h", tb_mem[20], ref_mem[20]); end
    run_single(1'b0, 1'b0, 32'd3, 32'h0);
    nvec++;
    if ((o_gnt !== 0) || (o_rv !== 3) || (o_rdata !== ref_mem[3]) || (o_err !== 1'b0)) begin
      nerr++; $display("FAIL midrst_after: got gnt %0d cyc %0d rdata %h required 0 3 %h", o_gnt, o_rv, o_rdata, ref_mem[3]);
    end
  endtask

  task automatic test_drop_req();
    int sc, rvc;
    logic [DW-1:0] held, got;
    held = if_rdata_snapshot_value();
    sc = 0; rvc = -1; got = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7;
    for (int k = 0; k < 8; k++) begin
      #1;
      if ((k == 0) && (d_gnt !== 1'b1)) sc++;
      if (if_gnt || if_rvalid) sc++;
      if (d_rvalid) begin rvc = k; got = d_rdata; end
      @(posedge clk); #1;
      d_req = 1'b0;
      if_req = (k == 0);
      if_addr = 32'd9;
    end
    if_req = 1'b0;
    nvec++;
    if (sc !== 0) begin nerr++; $display("FAIL drop_side_effect: got %0d events required 0", sc); end
    nvec++;
    if ((rvc !== 3) || (got !== ref_mem[7])) begin
      nerr++; $display("FAIL drop_d_resp: got cyc %0d rdata %h required 3 %h", rvc, got, ref_mem[7]);
    end
    nvec++;
    if (if_rdata !== held) begin nerr++; $display("FAIL drop_if_hold: got %h required %h", if_rdata, held); end
  endtask

  // Last fetch in test_reset_mid_wait read address 3.
  function automatic logic [DW-1:0] if_rdata_snapshot_value();
    return ref_mem[3];
  endfunction

  task automatic test_random();
    bit            pd, we, if_known, d_known;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, e_rd, e_if_rd, e_d_rd;
    logic          e_err, e_if_err, e_d_err;
    logic [19:0]   e_wm;
    int            e_lat, e_en;
    if_known = 1'b0; d_known = 1'b0;
    e_if_rd = 32'h0; e_d_rd = 32'h0; e_if_err = 1'b0; e_d_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pd   = 1'($urandom_range(0, 1));
      we   = pd ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 79));
      wd   = 32'($urandom);
      model_access(pd, we, addr, wd, e_lat, e_rd, e_err, e_en, e_wm);
      run_single(pd, we, addr, wd);
      nvec++;
      if ((o_gnt !== 0) || (o_rv !== e_lat)) begin
        nerr++; $display("FAIL rnd_timing[%0d]: got gnt %0d rvalid %0d required 0 %0d", i, o_gnt, o_rv, e_lat);
      end
      nvec++;
      if ((o_rdata !== e_rd) || (o_err !== e_err)) begin
        nerr++; $display("FAIL rnd_resp[%0d] addr %h: got %h/%b required %h/%b", i, addr, o_rdata, o_err, e_rd, e_err);
      end
      nvec++;
      if (($countones(en_mask) !== e_en) || (we_mask !== e_wm)) begin
        nerr++; $display("FAIL rnd_mem[%0d]: got en %b we %b required %0d ones, we %b", i, en_mask, we_mask, e_en, e_wm);
      end
      nvec++;
      if (stray !== 0) begin nerr++; $display("FAIL rnd_other_port[%0d]: got %0d events required 0", i, stray); end
      if (pd) begin d_known = 1'b1; e_d_rd = e_rd; e_d_err = e_err; end
      else begin if_known = 1'b1; e_if_rd = e_rd; e_if_err = e_err; end
      if (pd && if_known) begin
        nvec++;
        if ((if_rdata !== e_if_rd) || (if_err !== e_if_err)) begin
          nerr++; $display("FAIL rnd_if_hold[%0d]: got %h/%b required %h/%b", i, if_rdata, if_err, e_if_rd, e_if_err);
        end
      end
      if (!pd && d_known) begin
        nvec++;
        if ((d_rdata !== e_d_rd) || (d_err !== e_d_err)) begin
          nerr++; $display("FAIL rnd_d_hold[%0d]: got %h/%b required %h/%b", i, d_rdata, d_err, e_d_rd, e_d_err);
        end
      end
    end
    nvec++;
    if (tb_mem[10] !== ref_mem[10]) begin nerr++; $display("FAIL rnd_mem10: got %h required %h", tb_mem[10], ref_mem[10]); end
  endtask

  initial begin
    logic [DW-1:0] v;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    pre_we = 1'b0; pre_idx = 6'd0; pre_val = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      v = (i == 5) ? 32'h00A0_0005 : 32'($urandom);
      pre_we = 1'b1; pre_idx = 6'(i); pre_val = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;
    test_reset();
    test_fetch();
    test_write_then_fetch();
    test_out_of_range();
    test_round_robin();
    test_reset_mid_wait();
    test_drop_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data Memory between two requesters: the instruction-fetch port (if_*, read-only) and the data port (d_*, read/write).
- Arbitrates between the two ports, sequences each access through a fixed number of memory wait cycles, and returns a one-cycle response pulse to the port that owns the access.
- Flags addresses outside the memory range as errors and never drives them to the memory.
- Sits between the core's fetch/load-store logic and Memory; it is the only master of the memory pins.

Parameters:
- ADDR_W, 32, address width (word address, as on Memory).
- DATA_W, 32, data/instruction width.
- DEPTH, 64, number of valid words; any address >= DEPTH is out of range.
- WAIT_CYCLES, 2, cycles mem_en is held per access. Legal range is >= 1; values of 0 are illegal and are rejected at elaboration.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request accepted (one-cycle pulse).
- if_rvalid  out  1  fetch response valid (one-cycle pulse).
- if_rdata  out  DATA_W  fetched instruction.
- if_err  out  1  fetch address out of range; qualified by if_rvalid.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted (one-cycle pulse).
- d_rvalid  out  1  data response valid (one-cycle pulse).
- d_rdata  out  DATA_W  read data; 0 for writes.
- d_err  out  1  data address out of range; qualified by d_rvalid.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0.
  - last_owner is set to DATA, so the fetch port wins the first tie.
  - Any in-flight access is dropped: no rvalid is produced for it and no memory write happens.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If one port requests, that port wins.
  - If both ports request, the port that is not last_owner wins (round-robin).
  - The winner's gnt is high combinationally in this cycle.
  - On the clock edge: latch addr, we, wdata and owner, and update last_owner.
  - If the address is in range, go to WAIT with wcnt = WAIT_CYCLES-1.
  - If the address is out of range, go to RESP with err = 1 and rdata = 0; mem_en is never asserted for that access.
- WAIT:
  - mem_en = 1; mem_addr and mem_wdata come from the latched values.
  - mem_we = 1 only in the cycle where wcnt == 0, and only for writes.
  - wcnt decrements each cycle.
  - When wcnt == 0: capture mem_rdata into the rdata register (captures 0 for writes) and go to RESP.
- RESP:
  - The owner's rvalid = 1 for exactly one cycle; rdata and err are valid with it.
  - The other port's rvalid stays 0.
  - Next state is always IDLE. No grant is issued in RESP.
- Timing:
  - For a grant at cycle T: in-range rvalid is at T+WAIT_CYCLES+1; out-of-range rvalid is at T+1.
  - Peak throughput is one access per WAIT_CYCLES+2 cycles.
- gnt is asserted only in IDLE. A requester that drops req before gnt causes no side effect.
- rdata/err outputs hold their value after the rvalid pulse until the next response to the same port.
- Address compare is unsigned on the full ADDR_W bits.

Decomposition:
- Shared package mem_arb_pkg contains:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - owner encoding: OWN_IF=1'b0, OWN_D=1'b1;
  - the default DEPTH/WAIT_CYCLES constants.
- One sub-module, arb_rr2: a two-requester round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: one-hot gnt[1:0], winner.

Test Plan:
1. WAIT_CYCLES=2, mem[5]=0x00A0_0005, if_req addr 5 at cycle T → if_gnt at T; mem_en high T+1..T+2; if_rvalid at T+3 with if_rdata=0x00A0_0005 and if_err=0.
2. After reset, if_req and d_req held high continuously (reads, addr 1 and 2) → grant order F,D,F,D over four accesses; grants spaced 4 cycles apart.
3. d_req write, addr 10, wdata 0xDEAD_BEEF → mem_we high exactly one cycle (T+2), d_rvalid at T+3 with d_rdata=0. A following fetch of addr 10 returns 0xDEAD_BEEF.
4. DEPTH=64, d_req read addr 64 → d_gnt at T; d_rvalid at T+1 with d_err=1 and d_rdata=0; mem_en stays 0 throughout.
5. rst_n pulled low mid-WAIT (between edges) → all outputs 0 immediately. After release, no stale rvalid appears, and the next if_req addr 3 completes normally with rvalid at T+3.
